// File: rtl/reaper_io_pkg.sv
// Shared types and widths for the processor IN path: FSM encoding, bus widths and
// the switch-word extension helper.
package reaper_io_pkg;

  localparam int IO_SW_W = 18;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_PRESS = 2'd1,
    DONE       = 2'd2
  } io_state_e;

  function automatic logic [DATA_W-1:0] extend_sw(input logic [IO_SW_W-1:0] sw,
                                                  input logic               sign_ext);
    return {{(DATA_W-IO_SW_W){sign_ext & sw[IO_SW_W-1]}}, sw};
  endfunction

endpackage

// File: rtl/io_input_controller_if.sv
// Board-pin / processor-side bundle for the IN controller. The slave modport is the
// controller itself; the master modport is whatever drives the pins and the request.
interface io_input_controller_if;
  import reaper_io_pkg::*;

  logic                Raw_Button_I;
  logic [IO_SW_W-1:0]  Raw_Input;
  logic                In_Request;
  logic                Interrupt;
  logic [DATA_W-1:0]   Data_In;
  logic                Data_Valid;
  logic [7:0]          Press_Count;

  modport master (
    output Raw_Button_I, Raw_Input, In_Request,
    input  Interrupt, Data_In, Data_Valid, Press_Count
  );

  modport slave (
    input  Raw_Button_I, Raw_Input, In_Request,
    output Interrupt, Data_In, Data_Valid, Press_Count
  );

endinterface

// File: rtl/io_debounce.sv
// Synchronises an active-low asynchronous button, debounces it with a stability
// counter and emits a one-cycle pulse when the clean level goes to "pressed".
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic press
);

  logic             sync1;
  logic             btn;
  logic             clean;
  logic             clean_d;
  logic [CNT_W-1:0] cnt;

  // The synchroniser carries the inverted pin, so its cleared state means "released".
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      btn     <= 1'b0;
      clean   <= 1'b0;
      clean_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= ~raw_n;
      btn     <= sync1;
      clean_d <= clean;
      press   <= clean & ~clean_d;
      if (btn == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        clean <= btn;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_input_controller.sv
// Processor IN-path controller: stalls the core while an IN waits for a debounced
// button press, then latches the extended switch word and pulses Data_Valid.
module io_input_controller
  import reaper_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter bit SIGN_EXTEND     = 1'b0
) (
  input  logic                  Sys_Clock,
  input  logic                  Reset,
  io_input_controller_if.slave  io
);

  logic               press;
  logic [IO_SW_W-1:0] sw_s1;
  logic [IO_SW_W-1:0] sw_s2;
  io_state_e          state;

  io_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk   (Sys_Clock),
    .rst   (Reset),
    .raw_n (io.Raw_Button_I),
    .press (press)
  );

  always_ff @(posedge Sys_Clock or posedge Reset) begin
    if (Reset) begin
      sw_s1          <= '0;
      sw_s2          <= '0;
      state          <= IDLE;
      io.Data_In     <= '0;
      io.Data_Valid  <= 1'b0;
      io.Press_Count <= '0;
    end else begin
      sw_s1         <= io.Raw_Input;
      sw_s2         <= sw_s1;
      io.Data_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (io.In_Request) state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          // A withdrawn request wins over a coincident press: the IN is no longer live.
          if (!io.In_Request) begin
            state <= IDLE;
          end else if (press) begin
            state          <= DONE;
            io.Data_In     <= extend_sw(sw_s2, SIGN_EXTEND);
            io.Data_Valid  <= 1'b1;
            io.Press_Count <= io.Press_Count + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by Reset so the stall drops immediately, even with In_Request still high.
  assign io.Interrupt = io.In_Request & ~Reset & (state != DONE);

endmodule

// File: tb/tb_io_input_controller.sv
// Directed bench for io_input_controller: a zero-extending and a sign-extending
// instance share stimulus; vectors drive full press/capture transactions.
module tb_io_input_controller;
  import reaper_io_pkg::*;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_input_controller_if zx_if ();
  io_input_controller_if sx_if ();

  assign sx_if.Raw_Button_I = zx_if.Raw_Button_I;
  assign sx_if.Raw_Input    = zx_if.Raw_Input;
  assign sx_if.In_Request   = zx_if.In_Request;

  io_input_controller #(.DEBOUNCE_CYCLES(DB), .CNT_W(4), .SIGN_EXTEND(1'b0)) u_zx (
    .Sys_Clock (clk),
    .Reset     (rst),
    .io        (zx_if.slave)
  );

  io_input_controller #(.DEBOUNCE_CYCLES(DB), .CNT_W(4), .SIGN_EXTEND(1'b1)) u_sx (
    .Sys_Clock (clk),
    .Reset     (rst),
    .io        (sx_if.slave)
  );

  typedef struct {
    logic [17:0] sw;
    logic [31:0] exp_zx;
    logic [31:0] exp_sx;
  } vec_t;

  vec_t        vecs [5];
  int          n_tests   = 0;
  int          n_fail    = 0;
  int          exp_count = 0;
  logic [31:0] last_zx   = '0;
  logic [31:0] last_sx   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s/irq", tag),   zx_if.Interrupt,   32'd0);
    check($sformatf("%s/dv", tag),    zx_if.Data_Valid,  32'd0);
    check($sformatf("%s/data", tag),  zx_if.Data_In,     32'd0);
    check($sformatf("%s/count", tag), zx_if.Press_Count, 32'd0);
    check($sformatf("%s/sx_irq", tag), sx_if.Interrupt,  32'd0);
    check($sformatf("%s/sx_data", tag), sx_if.Data_In,   32'd0);
  endtask

  // Raise the request, press (optionally bouncing first) and expect one capture
  // exactly 2 + DB + 1 + 1 cycles after the final pin transition.
  task automatic press_and_capture(input string tag, input logic [17:0] sw,
                                   input logic [31:0] exp_zx, input logic [31:0] exp_sx,
                                   input bit bounce);
    int n;
    bit seen;
    bit stall_ok;
    @(negedge clk);
    zx_if.Raw_Input  = sw;
    zx_if.In_Request = 1'b1;
    #1 check($sformatf("%s/irq_rise", tag), zx_if.Interrupt, 32'd1);
    if (bounce) begin
      zx_if.Raw_Button_I = 1'b0; @(negedge clk);
      zx_if.Raw_Button_I = 1'b1; @(negedge clk);
      zx_if.Raw_Button_I = 1'b0; @(negedge clk);
      zx_if.Raw_Button_I = 1'b1; @(negedge clk);
    end
    zx_if.Raw_Button_I = 1'b0;
    n = 0; seen = 1'b0; stall_ok = 1'b1;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (zx_if.Data_Valid) seen = 1'b1;
      else if (!zx_if.Interrupt) stall_ok = 1'b0;
    end
    check($sformatf("%s/dv_seen", tag), seen, 32'd1);
    check($sformatf("%s/latency", tag), n, 32'd8);
    check($sformatf("%s/stall_held", tag), stall_ok, 32'd1);
    check($sformatf("%s/irq_drop", tag), zx_if.Interrupt, 32'd0);
    check($sformatf("%s/sx_dv", tag), sx_if.Data_Valid, 32'd1);
    check($sformatf("%s/data_zx", tag), zx_if.Data_In, exp_zx);
    check($sformatf("%s/data_sx", tag), sx_if.Data_In, exp_sx);
    exp_count = (exp_count + 1) % 256;
    check($sformatf("%s/count", tag), zx_if.Press_Count, 32'(exp_count));
    last_zx = exp_zx;
    last_sx = exp_sx;
    zx_if.In_Request = 1'b0;
    @(negedge clk);
    check($sformatf("%s/dv_one_cycle", tag), zx_if.Data_Valid, 32'd0);
    zx_if.Raw_Button_I = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dv_cnt;
    vecs[0] = '{18'h2A5A5, 32'h0002A5A5, 32'hFFFEA5A5};
    vecs[1] = '{18'h20001, 32'h00020001, 32'hFFFE0001};
    vecs[2] = '{18'h1FFFF, 32'h0001FFFF, 32'h0001FFFF};
    vecs[3] = '{18'h00000, 32'h00000000, 32'h00000000};
    vecs[4] = '{18'h3FFFF, 32'h0003FFFF, 32'hFFFFFFFF};

    // Power-on reset
    rst = 1'b1;
    zx_if.Raw_Button_I = 1'b1;
    zx_if.Raw_Input    = '0;
    zx_if.In_Request   = 1'b0;
    #1 check_all_zero("por");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("por_exit");
    repeat (4) @(negedge clk);

    // Table: clean presses, zero vs sign extension
    for (int i = 0; i < 5; i++)
      press_and_capture($sformatf("vec%0d", i), vecs[i].sw, vecs[i].exp_zx, vecs[i].exp_sx, 1'b0);

    // Bounce 0,1,0,1 then stable 0: one edge, timed from the last transition
    press_and_capture("bounce", 18'h0C3C3, 32'h0000C3C3, 32'h0000C3C3, 1'b1);

    // Button already held when the request rises
    @(negedge clk);
    zx_if.Raw_Button_I = 1'b0;
    repeat (12) @(negedge clk);
    check("held_pre/count", zx_if.Press_Count, 32'(exp_count));
    check("held_pre/data", zx_if.Data_In, last_zx);
    zx_if.Raw_Input  = 18'h3F0F0;
    zx_if.In_Request = 1'b1;
    dv_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (zx_if.Data_Valid) dv_cnt++;
    end
    check("held/no_capture", dv_cnt, 32'd0);
    check("held/stall", zx_if.Interrupt, 32'd1);
    zx_if.Raw_Button_I = 1'b1;
    repeat (12) @(negedge clk);
    check("held_release/no_dv", zx_if.Data_Valid, 32'd0);
    check("held_release/data", zx_if.Data_In, last_zx);
    press_and_capture("held_repress", 18'h15555, 32'h00015555, 32'h00015555, 1'b0);

    // Reset in the middle of WAIT_PRESS with random pins
    @(negedge clk);
    zx_if.Raw_Input    = 18'h2AAAA;
    zx_if.In_Request   = 1'b1;
    zx_if.Raw_Button_I = 1'b0;
    repeat (4) @(negedge clk);
    check("mid/stall_before_reset", zx_if.Interrupt, 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      zx_if.Raw_Input    = 18'($urandom);
      zx_if.In_Request   = 1'($urandom);
      zx_if.Raw_Button_I = 1'($urandom);
      #1 check_all_zero($sformatf("reset_hold%0d", i));
    end
    @(negedge clk);
    zx_if.In_Request   = 1'b0;
    zx_if.Raw_Button_I = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset_exit");
    exp_count = 0;
    repeat (12) @(negedge clk);

    // Presses with no IN pending are ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      zx_if.Raw_Input    = 18'h11111 * 18'(i + 1);
      zx_if.Raw_Button_I = 1'b0;
      repeat (12) @(negedge clk);
      check($sformatf("ignored%0d/data", i), zx_if.Data_In, 32'd0);
      check($sformatf("ignored%0d/count", i), zx_if.Press_Count, 32'd0);
      check($sformatf("ignored%0d/dv", i), zx_if.Data_Valid, 32'd0);
      zx_if.Raw_Button_I = 1'b1;
      repeat (12) @(negedge clk);
    end

    // 256 accepted presses: count wraps back to zero
    for (int i = 1; i <= 256; i++)
      press_and_capture($sformatf("wrap%0d", i), 18'(i), 32'(i), 32'(i), 1'b0);
    check("wrap/final_count", zx_if.Press_Count, 32'd0);
    check("wrap/final_data", zx_if.Data_In, 32'h00000100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
